caliptra_prim_reqack_src_queue: RTL and testbench
=================================================

// Module: caliptra_prim_reqack_src_queue
// PURPOSE
// - Source-domain front end for a REQ/ACK CDC synchronizer: collects single-cycle event pulses,
//   counts them, and replays them one at a time as a level REQ held until ACK.
// - req_o drives the synchronizer's SRC request; ack_i takes its one-cycle SRC acknowledge.
// - Guarantees the SRC-side rule: REQ never drops without ACK.
// - Adds overflow and ACK-timeout error flags.
// PARAMETERS
// - CntWidth      4  width of the pending-event counter; capacity 2**CntWidth-1 events
// - TimeoutCycles 0  ACK-wait limit in cycles; 0 disables timeout detection
// - TimeoutW      $clog2(TimeoutCycles+1)  derived, localparam, not overridable
// PORTS
// - clk_i        in   1         clock
// - rst_i        in   1         synchronous, active-high reset
// - evt_i        in   1         event pulse; each high cycle = one event
// - flush_i      in   1         discard queued events that are not yet in flight
// - err_clr_i    in   1         clear sticky error flags
// - req_o        out  1         REQ to synchronizer (level, registered)
// - ack_i        in   1         ACK from synchronizer (one-cycle pulse)
// - pending_o    out  CntWidth  events accepted but not yet acknowledged, including in-flight
// - busy_o       out  1         pending_o != 0
// - overflow_o   out  1         sticky: event dropped because counter saturated
// - timeout_o    out  1         sticky: REQ high TimeoutCycles cycles without ACK
// BEHAVIOUR
// - Interface: one clock clk_i; reset rst_i synchronous, active-high. On reset all state and all
//   outputs are 0, and the FSM is in IDLE.
// - FSM (enum in pkg) has two states:
//   - IDLE: req_o=0.
//   - REQ: req_o=1.
//   - req_o is decoded directly from the state register (no combinational path from inputs).
// - Handshake: hs = req_o & ack_i. ack_i while in IDLE is ignored and is flagged by an assertion.
// - Counter update: cnt_d = cnt_q + acc - hs.
//   - acc = evt_i & !flush_i & (cnt_q != MAX | hs), where MAX = 2**CntWidth-1.
//   - An ACK in the same cycle frees a slot, so evt_i at MAX with hs is accepted.
// - Overflow: evt_i & !flush_i & cnt_q==MAX & !hs sets overflow_o next cycle. The event is lost.
// - Flush: cnt_d = (REQ & !hs) ? 1 : 0. The in-flight REQ is kept and never withdrawn.
//   - evt_i in the flush cycle is dropped without setting overflow.
// - Transitions:
//   - IDLE -> REQ when cnt_d != 0. Latency: evt_i at cycle t gives req_o=1 at t+1.
//   - REQ -> IDLE on hs when cnt_d == 0. Otherwise stay in REQ and keep req_o high; the next
//     cycle is a new transaction.
//   - This back-to-back operation is legal for the NRZ synchronizer.
// - Timeout (TimeoutCycles>0):
//   - tmo_cnt clears on IDLE and on hs; it increments each REQ cycle without hs and saturates.
//   - timeout_o sets when tmo_cnt reaches TimeoutCycles-1 with no hs.
//   - req_o stays asserted after timeout.
//   - TimeoutCycles=0: the counter is not generated and timeout_o is tied to 0.
// - err_clr_i clears overflow_o and timeout_o. A set in the same cycle wins over the clear.
// - Outputs:
//   - pending_o = cnt_q.
//   - busy_o = |cnt_q.
// - Reset mid-handshake: req_o drops immediately. The paired DST domain must be reset in the
//   same window.
// - Assertions:
//   - req_o fell implies ack_i in the previous cycle.
//   - No ack_i while in IDLE.
//   - cnt_q==0 implies IDLE.
// STRUCTURE
// - caliptra_prim_reqack_pkg:
//   - reqack_src_fsm_e {IDLE, REQ}
//   - status struct {overflow, timeout} for CSR hookup
// - Single flat module; no sub-module. The timeout counter sits inside a generate-if on
//   TimeoutCycles.
// - Integration: req_o -> src_req_i and src_ack_o -> ack_i of the NRZ REQ/ACK synchronizer,
//   same clock.
// TESTING
// - Single event: evt_i pulse at t0 -> req_o=1 at t0+1, pending_o=1; ack_i at t0+5 ->
//   req_o=0 and pending_o=0 at t0+6.
// - Burst: 3 consecutive evt_i pulses -> req_o stays high across 3 ACKs, pending_o goes
//   3,2,1,0, then IDLE.
// - Saturation (CntWidth=2):
//   - 4 events with no ACK -> pending_o=3, overflow_o=1.
//   - evt_i with ack_i at count 3 -> pending_o remains 3, no new overflow.
// - Flush: pending_o=5 in REQ, flush_i -> pending_o=1 and req_o held high; ack_i ->
//   IDLE, pending_o=0.
// - Timeout (TimeoutCycles=8): REQ with no ACK -> timeout_o=1 after 8 REQ cycles and req_o
//   still 1; err_clr_i -> 0.
// - Reset: rst_i asserted while req_o=1 and pending_o=2 -> all outputs 0 next cycle;
//   ack_i in IDLE is ignored.

Source files
------------

// File: rtl/caliptra_prim_reqack_pkg.sv
// rtl/caliptra_prim_reqack_pkg.sv - shared types for the REQ/ACK source-side event queue
package caliptra_prim_reqack_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } reqack_src_fsm_e;

  typedef struct packed {
    logic overflow;
    logic timeout;
  } reqack_src_status_t;

endpackage

// File: rtl/caliptra_prim_reqack_src_queue.sv
// rtl/caliptra_prim_reqack_src_queue.sv - counts event pulses and replays them as level REQs held until ACK
module caliptra_prim_reqack_src_queue
  import caliptra_prim_reqack_pkg::*;
#(
  parameter int unsigned CntWidth      = 4,
  parameter int unsigned TimeoutCycles = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                evt_i,
  input  logic                flush_i,
  input  logic                err_clr_i,
  output logic                req_o,
  input  logic                ack_i,
  output logic [CntWidth-1:0] pending_o,
  output logic                busy_o,
  output logic                overflow_o,
  output logic                timeout_o
);

  localparam int unsigned TimeoutW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntWidth-1:0] CntMax = '1;
  localparam logic [CntWidth-1:0] CntOne = {{(CntWidth-1){1'b0}}, 1'b1};

  reqack_src_fsm_e     state_q;
  reqack_src_status_t  status_q;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                hs, at_max, acc, ovf_set, tmo_set;

  assign req_o   = (state_q == REQ);
  assign hs      = req_o & ack_i;
  assign at_max  = (cnt_q == CntMax);
  // A same-cycle ACK frees a slot, so an event at saturation is still accepted.
  assign acc     = evt_i & ~flush_i & (~at_max | hs);
  assign ovf_set = evt_i & ~flush_i & at_max & ~hs;

  always_comb begin
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = (req_o && !hs) ? CntOne : '0;
    end else begin
      cnt_d = cnt_q + {{(CntWidth-1){1'b0}}, acc} - {{(CntWidth-1){1'b0}}, hs};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      status_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        IDLE:    if (cnt_d != '0) state_q <= REQ;
        REQ:     if (hs && cnt_d == '0) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      status_q.overflow <= ovf_set | (status_q.overflow & ~err_clr_i);
      status_q.timeout  <= tmo_set | (status_q.timeout & ~err_clr_i);
    end
  end

  if (TimeoutCycles > 0) begin : g_tmo
    localparam logic [TimeoutW-1:0] TmoLast = TimeoutW'(TimeoutCycles - 1);
    logic [TimeoutW-1:0] tmo_cnt_q;

    // Saturating past TmoLast keeps the flag from re-arming, so a clear sticks.
    always_ff @(posedge clk_i) begin
      if (rst_i || !req_o || hs) begin
        tmo_cnt_q <= '0;
      end else if (tmo_cnt_q != '1) begin
        tmo_cnt_q <= tmo_cnt_q + TimeoutW'(1);
      end
    end

    assign tmo_set = req_o & ~hs & (tmo_cnt_q == TmoLast);
  end else begin : g_no_tmo
    assign tmo_set = 1'b0;
  end

  assign pending_o  = cnt_q;
  assign busy_o     = |cnt_q;
  assign overflow_o = status_q.overflow;
  assign timeout_o  = status_q.timeout;

`ifndef SYNTHESIS
  req_fall_needs_ack: assert property (@(posedge clk_i) disable iff (rst_i)
    $fell(req_o) |-> ($past(ack_i) || $past(rst_i)));
  no_ack_in_idle: assert property (@(posedge clk_i) disable iff (rst_i)
    ack_i |-> req_o);
  empty_means_idle: assert property (@(posedge clk_i) disable iff (rst_i)
    (cnt_q == '0) |-> (state_q == IDLE));
`endif

endmodule

// File: tb/tb_caliptra_prim_reqack_src_queue.sv
// tb/tb_caliptra_prim_reqack_src_queue.sv - directed scoreboard bench for the REQ/ACK source queue
module tb_caliptra_prim_reqack_src_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_evt, a_flush, a_clr, a_ack, a_req, a_busy, a_ovf, a_tmo;
  logic [3:0] a_pend;
  logic       b_evt, b_flush, b_clr, b_ack, b_req, b_busy, b_ovf, b_tmo;
  logic [1:0] b_pend;

  caliptra_prim_reqack_src_queue #(.CntWidth(4), .TimeoutCycles(8)) dut_a (
    .clk_i(clk), .rst_i(rst), .evt_i(a_evt), .flush_i(a_flush), .err_clr_i(a_clr),
    .req_o(a_req), .ack_i(a_ack), .pending_o(a_pend), .busy_o(a_busy),
    .overflow_o(a_ovf), .timeout_o(a_tmo)
  );

  caliptra_prim_reqack_src_queue #(.CntWidth(2), .TimeoutCycles(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .evt_i(b_evt), .flush_i(b_flush), .err_clr_i(b_clr),
    .req_o(b_req), .ack_i(b_ack), .pending_o(b_pend), .busy_o(b_busy),
    .overflow_o(b_ovf), .timeout_o(b_tmo)
  );

  typedef struct {
    string      tag;
    bit         inst_b;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [7:0] pack(logic req, logic [3:0] pend, logic ovf, logic tmo);
    return {req, (pend != 4'd0), pend, ovf, tmo};
  endfunction

  task automatic expect_a(string name, logic req, int pend, logic ovf, logic tmo);
    exp_t e;
    e.tag = name; e.inst_b = 1'b0; e.val = pack(req, 4'(pend), ovf, tmo);
    sb.push_back(e);
  endtask

  task automatic expect_b(string name, logic req, int pend, logic ovf, logic tmo);
    exp_t e;
    e.tag = name; e.inst_b = 1'b1; e.val = pack(req, 4'(pend), ovf, tmo);
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t       e;
    logic [7:0] obs;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = e.inst_b ? {b_req, b_busy, 2'b00, b_pend, b_ovf, b_tmo}
                     : {a_req, a_busy, a_pend, a_ovf, a_tmo};
      n_cmp++;
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s: observed req,busy,pend,ovf,tmo=%b expected %b", e.tag, obs, e.val);
      end
    end
    {a_evt, a_flush, a_clr, a_ack} = 4'b0;
    {b_evt, b_flush, b_clr, b_ack} = 4'b0;
  endtask

  initial begin
    rst = 1'b1;
    {a_evt, a_flush, a_clr, a_ack} = 4'b0;
    {b_evt, b_flush, b_clr, b_ack} = 4'b0;
    expect_a("reset_a", 0, 0, 0, 0);
    expect_b("reset_b", 0, 0, 0, 0);
    tick();
    rst = 1'b0;

    // single event: REQ one cycle after the pulse, dropped on the ACK
    a_evt = 1'b1; expect_a("single_req", 1, 1, 0, 0); tick();
    repeat (4) begin expect_a("single_hold", 1, 1, 0, 0); tick(); end
    a_ack = 1'b1; expect_a("single_ack", 0, 0, 0, 0); tick();

    // burst of three, REQ held across back-to-back ACKs
    for (int i = 1; i <= 3; i++) begin
      a_evt = 1'b1; expect_a("burst_evt", 1, i, 0, 0); tick();
    end
    for (int i = 2; i >= 0; i--) begin
      a_ack = 1'b1; expect_a("burst_ack", (i != 0), i, 0, 0); tick();
    end

    // flush keeps the in-flight REQ; event in the flush cycle dropped silently
    for (int i = 1; i <= 5; i++) begin
      a_evt = 1'b1; expect_a("flush_fill", 1, i, 0, 0); tick();
    end
    a_evt = 1'b1; a_flush = 1'b1; expect_a("flush_keep", 1, 1, 0, 0); tick();
    a_ack = 1'b1; expect_a("flush_ack", 0, 0, 0, 0); tick();
    for (int i = 1; i <= 2; i++) begin
      a_evt = 1'b1; expect_a("flush_hs_fill", 1, i, 0, 0); tick();
    end
    a_flush = 1'b1; a_ack = 1'b1; expect_a("flush_with_hs", 0, 0, 0, 0); tick();

    // saturation on the 2-bit instance
    for (int i = 1; i <= 4; i++) begin
      b_evt = 1'b1; expect_b("sat_evt", 1, (i > 3) ? 3 : i, (i == 4), 0); tick();
    end
    b_clr = 1'b1; expect_b("sat_clr", 1, 3, 0, 0); tick();
    b_evt = 1'b1; b_ack = 1'b1; expect_b("sat_evt_with_ack", 1, 3, 0, 0); tick();
    b_evt = 1'b1; b_clr = 1'b1; expect_b("sat_set_beats_clr", 1, 3, 1, 0); tick();
    b_clr = 1'b1; expect_b("sat_clr2", 1, 3, 0, 0); tick();
    for (int i = 2; i >= 0; i--) begin
      b_ack = 1'b1; expect_b("sat_drain", (i != 0), i, 0, 0); tick();
    end

    // ACK timeout after 8 REQ cycles, REQ stays up, clear sticks
    a_evt = 1'b1; expect_a("tmo_req", 1, 1, 0, 0); tick();
    for (int k = 1; k <= 8; k++) begin
      expect_a("tmo_wait", 1, 1, 0, (k == 8)); tick();
    end
    expect_a("tmo_sticky", 1, 1, 0, 1); tick();
    a_clr = 1'b1; expect_a("tmo_clr", 1, 1, 0, 0); tick();
    expect_a("tmo_after_clr", 1, 1, 0, 0); tick();

    // reset mid-handshake
    a_evt = 1'b1; expect_a("rst_pre", 1, 2, 0, 0); tick();
    rst = 1'b1; expect_a("rst_mid_a", 0, 0, 0, 0); expect_b("rst_mid_b", 0, 0, 0, 0); tick();
    a_ack = 1'b1; expect_a("rst_ack_idle", 0, 0, 0, 0); tick();
    rst = 1'b0; expect_a("post_rst", 0, 0, 0, 0); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
